scroll_ctrl: RTL and testbench

SCROLL_CTRL -- requirements
Module: scroll_ctrl

---
 rtl/scroll_pkg.sv | 37 +++
 rtl/tick_gen.sv | 36 +++
 rtl/scroll_ctrl.sv | 144 ++++++++++++++
 tb/tb_scroll_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared types and constants for the scrolling seven-segment message controller.
//   char_t      : 3-bit character code consumed by the per-digit decoders
//   CH_*        : character code constants (5 and 6 are undefined and pass through)
//   state_t     : scroll FSM states
//   def_char()  : default message content for a given digit position
package scroll_pkg;

    typedef logic [2:0] char_t;

    localparam char_t CH_D     = 3'd0;
    localparam char_t CH_E     = 3'd1;
    localparam char_t CH_ONE   = 3'd2;
    localparam char_t CH_ZERO  = 3'd3;
    localparam char_t CH_TWO   = 3'd4;
    localparam char_t CH_BLANK = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Default message: digits 0..2 carry "2", "E", "d"; everything else blank.
    localparam char_t DEF_MSG_0 = CH_TWO;
    localparam char_t DEF_MSG_1 = CH_E;
    localparam char_t DEF_MSG_2 = CH_D;

    function automatic char_t def_char(input int unsigned idx);
        case (idx)
            0:       return DEF_MSG_0;
            1:       return DEF_MSG_1;
            2:       return DEF_MSG_2;
            default: return CH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: scroll-step prescaler, counts 0..TICK_DIV-1 while run is high.
//   clk, rst : clock, asynchronous active-high reset
//   run      : count enable (count holds when low)
//   clr      : synchronous clear, wins over run
//   tick     : combinational pulse while run and count is at its last value
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = run & w_last;

    // Prescaler counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: rotates a NUM_DISP-digit character message across seven-segment positions.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : 1 = auto-scroll, 0 = pause
//   dir       : 0 = rotate left (pos+1), 1 = rotate right (pos-1)
//   step      : manual single step (rising edge), honoured only when not running
//   load      : one-cycle strobe capturing msg_in, clears pos and prescaler
//   msg_in    : new message
//   char_out  : rotated message, combinational from registered msg/pos
//   pos       : current rotation offset
//   tick      : combinational pulse on each automatic advance
// Build option: define SCROLL_CTRL_SYNC_EN to pass en/dir/step through
// two-flop synchronizers (2 cycles extra latency).
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int unsigned NUM_DISP = 8,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          dir,
    input  logic                          step,
    input  logic                          load,
    input  logic [NUM_DISP-1:0][2:0]      msg_in,
    output logic [NUM_DISP-1:0][2:0]      char_out,
    output logic [$clog2(NUM_DISP)-1:0]   pos,
    output logic                          tick
);

    localparam int unsigned PW = $clog2(NUM_DISP);

    logic                     w_en;
    logic                     w_dir;
    logic                     w_step;
    logic                     r_step_d;
    logic                     w_step_rise;
    logic                     w_adv;
    logic                     w_run;
    logic                     w_tick;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PW-1:0]            r_pos;
    logic [NUM_DISP-1:0][2:0] r_msg;

`ifdef SCROLL_CTRL_SYNC_EN
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;

    // Two-flop synchronizers for the asynchronous control inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {step, dir, en};
            r_sync2 <= r_sync1;
        end
    end

    assign {w_step, w_dir, w_en} = r_sync2;
`else
    assign w_en   = en;
    assign w_dir  = dir;
    assign w_step = step;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; IDLE is only re-entered through reset
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_run = 1'b1;
                if (!w_en) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_en) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .clr  (load),
        .tick (w_tick)
    );

    assign tick = w_tick;

    // Step edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= w_step;
        end
    end

    assign w_step_rise = w_step & ~r_step_d;
    assign w_adv       = w_tick | (w_step_rise & (r_state != ST_RUN));

    // Message and offset; load discards any coincident advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= '0;
            for (int unsigned i = 0; i < NUM_DISP; i++) begin
                r_msg[i] <= def_char(i);
            end
        end else if (load) begin
            r_pos <= '0;
            r_msg <= msg_in;
        end else if (w_adv) begin
            r_pos <= w_dir ? (r_pos - PW'(1)) : (r_pos + PW'(1));
        end
    end

    assign pos = r_pos;

    // char_out[i] = msg[(i - pos) mod NUM_DISP]; power-of-two width wraps naturally
    for (genvar g = 0; g < NUM_DISP; g++) begin : g_rot
        logic [PW-1:0] w_idx;
        assign w_idx       = PW'(g) - r_pos;
        assign char_out[g] = r_msg[w_idx];
    end

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: directed self-checking bench for scroll_ctrl (NUM_DISP=8, TICK_DIV=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_scroll_ctrl;

    localparam int unsigned ND = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                dir;
    logic                step;
    logic                load;
    logic [ND-1:0][2:0]  msg_in;
    logic [ND-1:0][2:0]  char_out;
    logic [2:0]          pos;
    logic                tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scroll_ctrl #(
        .NUM_DISP (ND),
        .TICK_DIV (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .step     (step),
        .load     (load),
        .msg_in   (msg_in),
        .char_out (char_out),
        .pos      (pos),
        .tick     (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ND-1:0][2:0] v8(input logic [2:0] c0, input logic [2:0] c1,
                                              input logic [2:0] c2, input logic [2:0] c3,
                                              input logic [2:0] c4, input logic [2:0] c5,
                                              input logic [2:0] c6, input logic [2:0] c7);
        logic [ND-1:0][2:0] v;
        v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3;
        v[4] = c4; v[5] = c5; v[6] = c6; v[7] = c7;
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance falling edges until tick is seen (bounded); n = edges advanced
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 16);
        check("tick_seen", 32'(tick), 32'd1);
    endtask

    initial begin
        logic [ND-1:0][2:0] def_v;
        logic [ND-1:0][2:0] all3;
        logic [ND-1:0][2:0] seq_v;
        int                 n;
        logic               seen;

        def_v = v8(3'd4, 3'd1, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
        all3  = v8(3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3);
        seq_v = v8(3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7);

        rst = 1'b1; en = 1'b0; dir = 1'b0; step = 1'b0; load = 1'b0; msg_in = '0;

        // Reset values, including with a load strobe held during reset
        cyc(2);
        check("rst_char", 32'(char_out), 32'(def_v));
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        load = 1'b1; msg_in = all3;
        cyc(1);
        check("rst_char_load", 32'(char_out), 32'(def_v));
        load = 1'b0;

        // Release with en=0: stays idle, no tick for 20 cycles
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tick !== 1'b0) seen = 1'b1;
        end
        check("idle_no_tick", 32'(seen), 32'd0);
        check("idle_char", 32'(char_out), 32'(def_v));
        check("idle_pos", 32'(pos), 32'd0);

        // Auto-scroll left
        en = 1'b1;
        wait_tick(n);
        check("first_tick_lat", 32'(n), 32'd4);
        check("pos_at_tick", 32'(pos), 32'd0);
        cyc(1);
        check("pos_tick1", 32'(pos), 32'd1);
        check("char_tick1", 32'(char_out), 32'(v8(3'd7, 3'd4, 3'd1, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7)));
        check("tick_low_after", 32'(tick), 32'd0);
        for (int k = 2; k <= 8; k++) begin
            wait_tick(n);
            check("tick_period", 32'(n), 32'd3);
            cyc(1);
            check("pos_run", 32'(pos), 32'(k % 8));
        end

        // Rotate right from pos 0; in-flight count not restarted
        dir = 1'b1;
        wait_tick(n);
        check("dir_tick_lat", 32'(n), 32'd3);
        cyc(1);
        check("pos_right", 32'(pos), 32'd7);
        check("char_right", 32'(char_out), 32'(v8(3'd1, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd4)));

        // Pause with the count frozen at 2, then manual steps
        dir = 1'b0;
        cyc(1);
        en = 1'b0;
        cyc(1);
        check("pause_tick", 32'(tick), 32'd0);
        check("pause_pos", 32'(pos), 32'd7);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
        check("step_wrap", 32'(pos), 32'd0);
        step = 1'b1;
        cyc(3);
        check("step_held_once", 32'(pos), 32'd1);
        step = 1'b0;
        cyc(1);
        check("step_pos", 32'(pos), 32'd1);
        check("pause_tick2", 32'(tick), 32'd0);

        // Resume: held count 2 gives a tick two cycles later
        en = 1'b1;
        wait_tick(n);
        check("resume_lat", 32'(n), 32'd2);
        cyc(1);
        check("resume_pos", 32'(pos), 32'd2);

        // Step ignored while running
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
        check("step_in_run", 32'(pos), 32'd2);
        wait_tick(n);
        check("run_tick_lat", 32'(n), 32'd1);

        // Load coinciding with tick wins
        load = 1'b1; msg_in = all3;
        cyc(1);
        load = 1'b0;
        check("load_pos", 32'(pos), 32'd0);
        check("load_char", 32'(char_out), 32'(all3));
        check("load_tick", 32'(tick), 32'd0);
        wait_tick(n);
        check("load_cnt_clr", 32'(n), 32'd3);
        cyc(1);
        check("load_next_pos", 32'(pos), 32'd1);

        // Distinct message, scroll to pos 5
        load = 1'b1; msg_in = seq_v;
        cyc(1);
        load = 1'b0;
        check("load2_pos", 32'(pos), 32'd0);
        check("load2_char", 32'(char_out), 32'(seq_v));
        repeat (5) begin
            wait_tick(n);
            cyc(1);
        end
        check("seq_pos5", 32'(pos), 32'd5);
        check("seq_char5", 32'(char_out), 32'(v8(3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2)));

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        check("arst_char", 32'(char_out), 32'(def_v));
        check("arst_pos", 32'(pos), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        cyc(2);
        rst = 1'b0;
        wait_tick(n);
        check("post_rst_lat", 32'(n), 32'd4);
        cyc(1);
        check("post_rst_pos", 32'(pos), 32'd1);
        check("post_rst_char", 32'(char_out), 32'(v8(3'd7, 3'd4, 3'd1, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
